// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: LANES x DW valid/ready stage; in_valid/in_ready/in_data -> out_valid/out_ready/out_data, flush, occupancy, stall_cycles
module pipe_stage_hs #(
  parameter int LANES = 4,
  parameter int DW = 32,
  parameter bit SKID = 1'b1,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_data,
  output logic [1:0]          occupancy,
  output logic [CW-1:0]       stall_cycles
);
  logic [LANES*DW-1:0] h, s;
  logic hv, sv, acc, drn;
  assign in_ready = SKID ? ~sv : (~hv | out_ready);
  assign acc = in_valid & in_ready;
  assign drn = hv & out_ready;
  assign out_valid = hv;
  assign out_data = hv ? h : '0;
  assign occupancy = {1'b0, hv} + {1'b0, sv};
  always_ff @(posedge clk) begin
    if (reset) begin
      hv <= 1'b0;
      sv <= 1'b0;
      h <= '0;
      s <= '0;
      stall_cycles <= '0;
    end else begin
      if (hv && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush) begin
        hv <= 1'b0;
        sv <= 1'b0;
        h <= '0;
        s <= '0;
      end else if (!SKID) begin
        if (acc) begin
          h <= in_data;
          hv <= 1'b1;
        end else if (drn) begin
          h <= '0;
          hv <= 1'b0;
        end
      end else if (!hv || drn) begin
        if (sv) begin
          h <= s;
          hv <= 1'b1;
          s <= '0;
          sv <= 1'b0;
        end else if (acc) begin
          h <= in_data;
          hv <= 1'b1;
        end else begin
          h <= '0;
          hv <= 1'b0;
        end
      end else if (acc) begin
        s <= in_data;
        sv <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench for skid, combinational-ready and CW=4 variants of pipe_stage_hs
module tb_pipe_stage_hs;
  localparam int LANES = 4;
  localparam int DW = 32;
  localparam int W = LANES * DW;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] od [3];
  logic ov [3], ir [3];
  logic [1:0] oc [3];
  logic [15:0] sc0, sc1;
  logic [3:0] sc2;
  int total = 0, bad = 0;
  int cnt [3] = '{0, 0, 0};
  int st [3] = '{0, 0, 0};
  logic [W-1:0] sb [3][$];
  always #5 clk = ~clk;

  pipe_stage_hs #(.LANES(LANES), .DW(DW), .SKID(1'b1), .CW(16)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(oc[0]), .stall_cycles(sc0));
  pipe_stage_hs #(.LANES(LANES), .DW(DW), .SKID(1'b0), .CW(16)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(oc[1]), .stall_cycles(sc1));
  pipe_stage_hs #(.LANES(LANES), .DW(DW), .SKID(1'b1), .CW(4)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(oc[2]), .stall_cycles(sc2));

  function automatic bit rdy_m(int i);
    return (i == 1) ? (cnt[i] == 0 || out_ready) : (cnt[i] < 2);
  endfunction

  function automatic int max_st(int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic logic [15:0] st_dut(int i);
    return (i == 0) ? sc0 : (i == 1) ? sc1 : {12'b0, sc2};
  endfunction

  task automatic chk(string n, int i, logic [W-1:0] a, logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s u%0d @%0t got=%h exp=%h", n, i, $time, a, e);
    end
  endtask

  // reference model: a bounded FIFO of capacity 1 (SKID=0) or 2 (SKID=1)
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        cnt[i] = 0;
        st[i] = 0;
        sb[i].delete();
      end else begin
        bit a, d;
        if (cnt[i] > 0 && !out_ready && st[i] < max_st(i)) st[i]++;
        a = in_valid && rdy_m(i);
        d = cnt[i] > 0 && out_ready;
        if (flush) begin
          cnt[i] = 0;
          sb[i].delete();
        end else begin
          cnt[i] = cnt[i] + int'(a) - int'(d);
          if (a) sb[i].push_back(in_data);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, W'(ov[i]), W'(cnt[i] > 0));
      chk("out_data", i, od[i], (cnt[i] > 0 && sb[i].size() > 0) ? sb[i][0] : '0);
      chk("occupancy", i, W'(oc[i]), W'(cnt[i]));
      chk("in_ready", i, W'(ir[i]), W'(rdy_m(i)));
      chk("stall_cycles", i, W'(st_dut(i)), W'(st[i]));
      if (ov[i] && out_ready && !reset) begin
        if (sb[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_empty u%0d @%0t got=drain exp=no_entry", i, $time);
        end else void'(sb[i].pop_front());
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rnd_data();
    for (int k = 0; k < LANES; k++) in_data[k*DW +: DW] = $urandom;
  endtask

  initial begin
    in_valid = 1'b1;
    in_data = '1;
    cyc(2);
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cyc(2);
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data = W'(k * 17);
      cyc();
    end
    in_valid = 1'b0;
    cyc(3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(32'h11);
    cyc();
    in_data = W'(32'h22);
    cyc();
    in_data = W'(32'h33);
    cyc(3);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(4);
    for (int j = 0; j < 16; j++) begin
      in_valid = 1'b1;
      rnd_data();
      out_ready = j[0];
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(32'hA);
    cyc();
    in_data = W'(32'hB);
    cyc();
    flush = 1'b1;
    in_data = W'(32'hC);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    cyc(2);
    in_valid = 1'b1;
    rnd_data();
    cyc();
    in_valid = 1'b0;
    cyc(20);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(2);
    for (int j = 0; j < 400; j++) begin
      in_valid = $urandom_range(0, 3) != 0;
      rnd_data();
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      reset = $urandom_range(0, 99) == 0;
      cyc();
    end
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
